// File: rtl/nor_op_sequencer.sv
// Multi-cycle logic-function evaluator built around one shared WIDTH-bit NOR unit.
// Each op is a fixed microsequence of NOR steps through scratch registers t/u/v/r.
module nor_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nor_count
);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_U, SRC_V, SRC_R} src_t;
  typedef enum logic [1:0] {DST_T, DST_U, DST_V, DST_R} dst_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [2:0]       step;
  logic             illegal_pend;
  logic [WIDTH-1:0] a_q, b_q, t_q, u_q, v_q, r_q;

  src_t             src_x, src_y;
  dst_t             dst;
  logic             last;
  logic [WIDTH-1:0] nor_x, nor_y, nor_out;

  // Microcode: operand selects, destination and last-step flag for (op_q, step).
  // Intermediate "r" goes to r_q so the visible result only moves at completion.
  always_comb begin
    src_x = SRC_A;
    src_y = SRC_A;
    dst   = DST_R;
    last  = 1'b1;
    case (op_q)
      3'd1: begin
        if (step == 3'd0) begin
          src_y = SRC_B; dst = DST_T; last = 1'b0;
        end else begin
          src_x = SRC_T; src_y = SRC_T;
        end
      end
      3'd2, 3'd3: begin
        case (step)
          3'd0: begin dst = DST_T; last = 1'b0; end
          3'd1: begin src_x = SRC_B; src_y = SRC_B; dst = DST_U; last = 1'b0; end
          3'd2: begin src_x = SRC_T; src_y = SRC_U; last = (op_q == 3'd2); end
          default: begin src_x = SRC_R; src_y = SRC_R; end
        endcase
      end
      3'd4: src_y = SRC_B;
      3'd5, 3'd6: begin
        case (step)
          3'd0: begin src_y = SRC_B; dst = DST_T; last = 1'b0; end
          3'd1: begin src_y = SRC_T; dst = DST_U; last = 1'b0; end
          3'd2: begin src_x = SRC_B; src_y = SRC_T; dst = DST_V; last = 1'b0; end
          3'd3: begin src_x = SRC_U; src_y = SRC_V; last = (op_q == 3'd5); end
          default: begin src_x = SRC_R; src_y = SRC_R; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (src_x)
      SRC_A:   nor_x = a_q;
      SRC_B:   nor_x = b_q;
      SRC_T:   nor_x = t_q;
      SRC_U:   nor_x = u_q;
      SRC_V:   nor_x = v_q;
      default: nor_x = r_q;
    endcase
    case (src_y)
      SRC_A:   nor_y = a_q;
      SRC_B:   nor_y = b_q;
      SRC_T:   nor_y = t_q;
      SRC_U:   nor_y = u_q;
      SRC_V:   nor_y = v_q;
      default: nor_y = r_q;
    endcase
    nor_out = ~(nor_x | nor_y);
  end

  // Illegal op never enters EXEC; it reports done/err one cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      step         <= '0;
      illegal_pend <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      t_q          <= '0;
      u_q          <= '0;
      v_q          <= '0;
      r_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      nor_count    <= '0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      illegal_pend <= 1'b0;
      if (illegal_pend) begin
        done      <= 1'b1;
        err       <= 1'b1;
        result    <= '0;
        nor_count <= '0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 3'd7) begin
              illegal_pend <= 1'b1;
            end else begin
              a_q   <= a;
              b_q   <= b;
              op_q  <= op;
              step  <= '0;
              busy  <= 1'b1;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          case (dst)
            DST_T:   t_q <= nor_out;
            DST_U:   u_q <= nor_out;
            DST_V:   v_q <= nor_out;
            default: r_q <= nor_out;
          endcase
          if (last) begin
            result    <= nor_out;
            nor_count <= step + 3'd1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            step <= step + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_op_sequencer.sv
// Randomized and directed bench for nor_op_sequencer against a bitwise-function model.
module tb_nor_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done, err;
  logic [3:0] result;
  logic [2:0] nor_count;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] last_result = '0;

  nor_op_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result(result), .nor_count(nor_count)
  );

  always #5 clk = ~clk;

  // Reference: the boolean function itself and its NOR step count.
  function automatic logic [3:0] model_result(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    case (o)
      3'd0: return ~x;
      3'd1: return x | y;
      3'd2: return x & y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x ^ y;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int model_steps(input logic [2:0] o);
    int tbl [8] = '{1, 2, 3, 4, 1, 4, 5, 0};
    return tbl[o];
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] exp_r, input int exp_s, input string name);
    int lat;
    logic exp_busy, exp_done, exp_err;
    lat = (o == 3'd7) ? 1 : exp_s;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      exp_busy = (o != 3'd7) && (c < lat);
      exp_done = (c == lat);
      exp_err  = (c == lat) && (o == 3'd7);
      n_checks++;
      if (busy !== exp_busy) begin n_fail++; $display("[TB] FAIL %s busy c%0d: got %b want %b", name, c, busy, exp_busy); end
      n_checks++;
      if (done !== exp_done) begin n_fail++; $display("[TB] FAIL %s done c%0d: got %b want %b", name, c, done, exp_done); end
      n_checks++;
      if (err !== exp_err) begin n_fail++; $display("[TB] FAIL %s err c%0d: got %b want %b", name, c, err, exp_err); end
      if (c < lat) begin
        n_checks++;
        if (result !== last_result) begin n_fail++; $display("[TB] FAIL %s hold c%0d: got %b want %b", name, c, result, last_result); end
      end else begin
        n_checks++;
        if (result !== exp_r) begin n_fail++; $display("[TB] FAIL %s result: got %b want %b", name, result, exp_r); end
        n_checks++;
        if (nor_count !== 3'(exp_s)) begin n_fail++; $display("[TB] FAIL %s nor_count: got %0d want %0d", name, nor_count, exp_s); end
      end
    end
    last_result = exp_r;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL %s pulse_end: got done=%b err=%b want 0 0", name, done, err); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err, result, nor_count} !== 10'b0) begin
      n_fail++; $display("[TB] FAIL reset outputs: got busy=%b done=%b err=%b result=%b cnt=%0d want all 0", busy, done, err, result, nor_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_result = 4'b0000;
  endtask

  task automatic test_directed;
    logic [3:0] exp_tbl [7] = '{4'b0011, 4'b1110, 4'b1000, 4'b0111, 4'b0001, 4'b1001, 4'b0110};
    int         cnt_tbl [7] = '{1, 2, 3, 4, 1, 4, 5};
    for (int i = 0; i < 7; i++)
      run_op(3'(i), 4'b1100, 4'b1010, exp_tbl[i], cnt_tbl[i], $sformatf("directed_op%0d", i));
  endtask

  task automatic test_illegal;
    run_op(3'd7, 4'b1111, 4'b0101, 4'b0000, 0, "illegal_op");
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [3:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 4'($urandom);
      y = 4'($urandom);
      run_op(o, x, y, model_result(o, x, y), model_steps(o), $sformatf("random%0d_op%0d", i, o));
    end
  endtask

  task automatic test_busy_ignore;
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 4'b1100; b = 4'b1010;
    @(posedge clk); #1;
    op = 3'd1; a = 4'b0101; b = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 2) start = 1'b0;
      n_checks++;
      if (done !== (c == 3)) begin n_fail++; $display("[TB] FAIL ignore done c%0d: got %b want %b", c, done, (c == 3)); end
    end
    n_checks++;
    if (result !== 4'b1000 || nor_count !== 3'd3) begin
      n_fail++; $display("[TB] FAIL ignore and_result: got %b/%0d want 1000/3", result, nor_count);
    end
    start = 1'b1; op = 3'd1; a = 4'b1100; b = 4'b1010;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 4'b1000) begin
      n_fail++; $display("[TB] FAIL done_cycle_accept: got busy=%b done=%b result=%b want 1 0 1000", busy, done, result);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || result !== 4'b1110 || nor_count !== 3'd2) begin
      n_fail++; $display("[TB] FAIL done_cycle_or: got done=%b result=%b cnt=%0d want 1 1110 2", done, result, nor_count);
    end
    last_result = 4'b1110;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 4'b1100; b = 4'b1010;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, err, result, nor_count} !== 10'b0) begin
      n_fail++; $display("[TB] FAIL reset_mid outputs: got busy=%b done=%b err=%b result=%b cnt=%0d want all 0", busy, done, err, result, nor_count);
    end
    last_result = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mid quiet c%0d: got done=%b busy=%b want 0 0", c, done, busy); end
    end
    run_op(3'd0, 4'b0101, 4'b0000, 4'b1010, 1, "not_after_reset");
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [6];
    logic [3:0] xs [6], ys [6];
    logic [3:0] exp_r;
    int s;
    for (int i = 0; i < 6; i++) begin
      ops[i] = 3'($urandom_range(0, 6)); xs[i] = 4'($urandom); ys[i] = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b1; op = ops[0]; a = xs[0]; b = ys[0];
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b%0d accept: got busy=%b done=%b want 1 0", i, busy, done); end
      s = model_steps(ops[i]);
      exp_r = model_result(ops[i], xs[i], ys[i]);
      for (int c = 1; c <= s; c++) begin
        @(posedge clk); #1;
        if (c < s) begin
          n_checks++;
          if (done !== 1'b0 || result !== last_result) begin n_fail++; $display("[TB] FAIL b2b%0d mid c%0d: got done=%b result=%b want 0 %b", i, c, done, result, last_result); end
        end else begin
          n_checks++;
          if (done !== 1'b1 || result !== exp_r || nor_count !== 3'(s)) begin
            n_fail++; $display("[TB] FAIL b2b%0d op%0d: got done=%b result=%b cnt=%0d want 1 %b %0d", i, ops[i], done, result, nor_count, exp_r, s);
          end
          last_result = exp_r;
          if (i < 5) begin start = 1'b1; op = ops[i+1]; a = xs[i+1]; b = ys[i+1]; end
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b end: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_op_sequencer.md
Name: nor_op_sequencer

Overview:
- Multi-cycle controller that evaluates logic functions by time-multiplexing one shared WIDTH-bit two-input NOR unit.
- Each requested function (NOT, OR, AND, NAND, NOR, XNOR, XOR) is decomposed into a fixed microsequence of NOR steps.
- Intermediate values are held in scratch registers between steps.
- Sits between a lab test harness or top-level and the universal-gate datapath; exposes a start/busy/done handshake.

Parameters:
- WIDTH, 4, bit width of operands, scratch registers and result (bitwise operation).

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  3  function select: 0 NOT a, 1 OR, 2 AND, 3 NAND, 4 NOR, 5 XNOR, 6 XOR, 7 illegal
- a  input  WIDTH  operand A, sampled on the accept edge
- b  input  WIDTH  operand B, sampled on the accept edge
- busy  output  1  high while microsequence executing
- done  output  1  one-cycle pulse when result valid
- err  output  1  one-cycle pulse with done for op=7
- result  output  WIDTH  final value, held until next completion
- nor_count  output  3  NOR steps used by the last completed op

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, err=0, result=0, nor_count=0, scratch and step counter=0.
- States: IDLE, EXEC.
- IDLE:
  - start=1 with op in 0..6: latch a, b, op; step=0; go to EXEC.
  - start=1 with op=7: stay in IDLE; next cycle done=1, err=1, result=0, nor_count=0.
- EXEC: exactly one NOR per cycle, out = ~(x|y), into scratch t/u/v or result. Step count S per op:
  - NOT: r=NOR(a,a); S=1
  - NOR: r=NOR(a,b); S=1
  - OR: t=NOR(a,b); r=NOR(t,t); S=2
  - AND: t=NOR(a,a); u=NOR(b,b); r=NOR(t,u); S=3
  - NAND: AND sequence, then r=NOR(r,r); S=4
  - XNOR: t=NOR(a,b); u=NOR(a,t); v=NOR(b,t); r=NOR(u,v); S=4
  - XOR: XNOR sequence, then r=NOR(r,r); S=5
- Final step:
  - Write result and nor_count=S.
  - Return to IDLE.
  - done=1 for exactly the following cycle.
- Latency: start accepted at edge k; done high from edge k+S to edge k+S+1. busy high from edge k to edge k+S.
- start while busy=1: ignored, no queuing; latched operands are unaffected by input changes.
- start in the cycle done=1: accepted (state is IDLE); done drops next cycle; result holds until the new completion.
- result and nor_count change only at completion; between ops they hold their last value.
- Widths: all operations bitwise, no carries; nor_count is 3 bits (max 5).
- Reset mid-EXEC: immediate abort, all outputs to reset values, no done pulse; the next accepted start runs normally.

Test Plan:
- WIDTH=4, a=4'b1100, b=4'b1010, op=2 (AND) -> busy 3 cycles; done pulse at k+3; result=4'b1000; nor_count=3.
- Same operands, op=6 (XOR) -> done at k+5; result=4'b0110; nor_count=5. op=5 (XNOR) -> result=4'b1001 at k+4.
- Sweep op 0,1,3,4 with same operands -> results 4'b0011, 4'b1110, 4'b0111, 4'b0001; nor_count 1, 2, 4, 1.
- op=7 with start -> busy stays 0; done=1 and err=1 for one cycle at k+1; result=0; nor_count=0.
- Start AND, then pulse start with op=1 and change a/b mid-EXEC -> second request ignored; result=4'b1000. Then start OR in the done cycle -> accepted; result=4'b1110 two cycles later.
- Start XOR, drop rst_n at step 2 -> busy=0, done never pulses, result=0. Release reset, start NOT a=4'b0101 -> result=4'b1010 at k+1.
